// File: rtl/ucie_ctl_req_rsp_fsm_pkg.sv
// Shared definitions for the UCIe control request/response handshake controller:
// state encoding, parameter defaults and a small state-decode helper.
package ucie_ctl_req_rsp_fsm_pkg;

    localparam int MSG_W_DEF     = 8;
    localparam int MAX_RETRY_DEF = 3;
    localparam int RSP_BIT_DEF   = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_SEND) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/ucie_ctl_req_rsp_fsm_if.sv
// Handshake bundle between the request/response controller, the sideband TX/RX,
// the sibling Timer and the issuing control FSM.
interface ucie_ctl_req_rsp_fsm_if #(
    parameter int MSG_W     = 8,
    parameter int MAX_RETRY = 3,
    parameter int RC_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
);
    logic             start;
    logic             abort;
    logic [MSG_W-1:0] req_msg;
    logic             long_tmo;
    logic             tx_valid;
    logic             tx_ready;
    logic [MSG_W-1:0] tx_msg;
    logic             rsp_valid;
    logic [MSG_W-1:0] rsp_msg;
    logic             timer_en;
    logic             timer_long;
    logic             timer_flag;
    logic             busy;
    logic             done;
    logic             error;
    logic [RC_W-1:0]  retry_cnt;

    // Controller side
    modport master (
        input  start, abort, req_msg, long_tmo, tx_ready, rsp_valid, rsp_msg, timer_flag,
        output tx_valid, tx_msg, timer_en, timer_long, busy, done, error, retry_cnt
    );

    // Environment side (issuer, sideband, Timer)
    modport slave (
        output start, abort, req_msg, long_tmo, tx_ready, rsp_valid, rsp_msg, timer_flag,
        input  tx_valid, tx_msg, timer_en, timer_long, busy, done, error, retry_cnt
    );

endinterface

// File: rtl/ucie_ctl_req_rsp_fsm.sv
// Sends one sideband request, waits for the matching response using the external
// Timer flag as timeout, re-sends up to MAX_RETRY times, then reports error.
module ucie_ctl_req_rsp_fsm
    import ucie_ctl_req_rsp_fsm_pkg::*;
#(
    parameter int MSG_W     = MSG_W_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int RSP_BIT   = RSP_BIT_DEF,
    parameter int RC_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ucie_ctl_req_rsp_fsm_if.master bus
);

    localparam logic [MSG_W-1:0] RSP_MASK  = MSG_W'(1'b1) << RSP_BIT;
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRY);

    state_t           state_r;
    state_t           state_next;
    logic [MSG_W-1:0] msg_r;
    logic [MSG_W-1:0] msg_next;
    logic             long_r;
    logic             long_next;
    logic [RC_W-1:0]  retry_r;
    logic [RC_W-1:0]  retry_next;
    logic             tx_valid_r;
    logic             timer_en_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic             match_s;

    // A response matches when it is the latched request with the response bit set
    assign match_s = bus.rsp_valid && (bus.rsp_msg == (msg_r | RSP_MASK));

    // Next-state, latch and retry-counter decode; abort beats every other event
    always_comb begin
        state_next = state_r;
        msg_next   = msg_r;
        long_next  = long_r;
        retry_next = retry_r;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    if (bus.start) begin
                        state_next = ST_SEND;
                        msg_next   = bus.req_msg;
                        long_next  = bus.long_tmo;
                        retry_next = {RC_W{1'b0}};
                    end else begin
                        state_next = state_r;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
                ST_WAIT: begin
                    // Response is checked first so a same-cycle timeout cannot win
                    if (match_s) begin
                        state_next = ST_DONE;
                    end else if (bus.timer_flag) begin
                        if (retry_r < RETRY_MAX) begin
                            retry_next = retry_r + RC_W'(1'b1);
                            state_next = ST_SEND;
                        end else begin
                            state_next = ST_ERROR;
                        end
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, latches and outputs all registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            msg_r      <= {MSG_W{1'b0}};
            long_r     <= 1'b0;
            retry_r    <= {RC_W{1'b0}};
            tx_valid_r <= 1'b0;
            timer_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_next;
            msg_r      <= msg_next;
            long_r     <= long_next;
            retry_r    <= retry_next;
            tx_valid_r <= (state_next == ST_SEND);
            timer_en_r <= (state_next == ST_WAIT);
            busy_r     <= is_busy(state_next);
            done_r     <= (state_next == ST_DONE);
            error_r    <= (state_next == ST_ERROR);
        end
    end

    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_msg     = msg_r;
    assign bus.timer_en   = timer_en_r;
    assign bus.timer_long = long_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.error      = error_r;
    assign bus.retry_cnt  = retry_r;

endmodule

// File: tb/tb_ucie_ctl_req_rsp_fsm.sv
// Directed bench for ucie_ctl_req_rsp_fsm with a behavioural Timer (short/long period)
// wired to timer_en/timer_long/timer_flag.
module tb_ucie_ctl_req_rsp_fsm;

    localparam int SHORT_P = 6;
    localparam int LONG_P  = 15;
    // Handshake-to-handshake distance on a timeout: Timer period, flag sample, SEND cycle
    localparam int SHORT_GAP = SHORT_P + 2;
    localparam int LONG_GAP  = LONG_P + 2;
    localparam int BUDGET    = 300;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   tcnt;
    int   hs_cnt;
    int   done_cnt;
    int   hs_cyc [0:63];
    int   err_cyc;
    int   base;
    int   dbase;

    ucie_ctl_req_rsp_fsm_if bus ();

    ucie_ctl_req_rsp_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_valid && bus.tx_ready) begin
            hs_cyc[hs_cnt % 64] <= cyc;
            hs_cnt <= hs_cnt + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    // Timer model: counts while enabled, one-cycle flag after the selected period
    always @(posedge clk) begin
        if (rst || !bus.timer_en) begin
            tcnt           <= 0;
            bus.timer_flag <= 1'b0;
        end else if (tcnt == (bus.timer_long ? LONG_P : SHORT_P) - 1) begin
            tcnt           <= 0;
            bus.timer_flag <= 1'b1;
        end else begin
            tcnt           <= tcnt + 1;
            bus.timer_flag <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n = 0;
        while (hs_cnt < target && n < BUDGET) begin
            step();
            n++;
        end
        check(tag, 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic start_txn(input logic [7:0] req, input logic lng);
        bus.start    = 1'b1;
        bus.req_msg  = req;
        bus.long_tmo = lng;
        step();
        bus.start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_txv"}, 32'(bus.tx_valid), 32'd0);
        check({tag, "_ten"}, 32'(bus.timer_en), 32'd0);
        check({tag, "_dn"},  32'(bus.done),     32'd0);
        check({tag, "_bsy"}, 32'(bus.busy),     32'd0);
        check({tag, "_err"}, 32'(bus.error),    32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc = 0;
        hs_cnt = 0;
        done_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.req_msg = 8'h00;
        bus.long_tmo = 1'b0;
        bus.tx_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_msg = 8'h00;
        repeat (3) step();

        // Reset state
        check_quiet("rst");
        check("rst_msg",  32'(bus.tx_msg),     32'h00);
        check("rst_long", 32'(bus.timer_long), 32'd0);
        check("rst_rc",   32'(bus.retry_cnt),  32'd0);
        rst = 1'b0;
        step();

        // 1: immediate matching response
        dbase = done_cnt;
        start_txn(8'h05, 1'b0);
        check("t1_txv", 32'(bus.tx_valid), 32'd1);
        check("t1_msg", 32'(bus.tx_msg),   32'h05);
        check("t1_bsy", 32'(bus.busy),     32'd1);
        step();
        check("t1_ten", 32'(bus.timer_en), 32'd1);
        check("t1_txv0", 32'(bus.tx_valid), 32'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h85;
        step();
        bus.rsp_valid = 1'b0;
        check("t1_done", 32'(bus.done),      32'd1);
        check("t1_rc",   32'(bus.retry_cnt), 32'd0);
        step();
        check("t1_done0", 32'(bus.done),     32'd0);
        check("t1_ten0",  32'(bus.timer_en), 32'd0);
        check("t1_dcnt",  32'(done_cnt - dbase), 32'd1);

        // 2: no response, short timeout, retries exhaust into ERROR
        base = hs_cnt;
        start_txn(8'h05, 1'b0);
        wait_hs(base + 4, "t2_hs4");
        begin
            int n = 0;
            while (!bus.error && n < BUDGET) begin
                step();
                n++;
            end
            err_cyc = cyc;
        end
        check("t2_err",  32'(bus.error),       32'd1);
        check("t2_rc",   32'(bus.retry_cnt),   32'd3);
        check("t2_nhs",  32'(hs_cnt - base),   32'd4);
        check("t2_ten",  32'(bus.timer_en),    32'd0);
        check("t2_txv",  32'(bus.tx_valid),    32'd0);
        for (int i = 1; i < 4; i++)
            check($sformatf("t2_gap%0d", i), 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 32'(SHORT_GAP));
        check("t2_errlat", 32'(err_cyc - hs_cyc[base + 3]), 32'(SHORT_GAP));
        repeat (3) step();
        check("t2_errhold", 32'(bus.error), 32'd1);

        // 3: restart from ERROR with long timeout, answered on the 2nd attempt
        base = hs_cnt;
        start_txn(8'h05, 1'b1);
        check("t3_err0", 32'(bus.error),      32'd0);
        check("t3_txv",  32'(bus.tx_valid),   32'd1);
        check("t3_rc0",  32'(bus.retry_cnt),  32'd0);
        check("t3_long", 32'(bus.timer_long), 32'd1);
        wait_hs(base + 2, "t3_hs2");
        check("t3_gap",  32'(hs_cyc[base + 1] - hs_cyc[base]), 32'(LONG_GAP));
        check("t3_long2", 32'(bus.timer_long), 32'd1);
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h85;
        step();
        bus.rsp_valid = 1'b0;
        check("t3_done", 32'(bus.done),      32'd1);
        check("t3_rc",   32'(bus.retry_cnt), 32'd1);
        step();
        check("t3_rchold", 32'(bus.retry_cnt), 32'd1);

        // 4: mismatching response ignored, then the match completes
        dbase = done_cnt;
        start_txn(8'h05, 1'b0);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h06;
        step();
        check("t4_nodone", 32'(bus.done),     32'd0);
        check("t4_wait",   32'(bus.timer_en), 32'd1);
        bus.rsp_msg = 8'h85;
        step();
        bus.rsp_valid = 1'b0;
        check("t4_done", 32'(bus.done), 32'd1);
        step();
        check("t4_dcnt", 32'(done_cnt - dbase), 32'd1);

        // 5: match and timer flag together, response wins
        start_txn(8'h05, 1'b0);
        step();
        begin
            int n = 0;
            while (!bus.timer_flag && n < BUDGET) begin
                step();
                n++;
            end
        end
        check("t5_flag", 32'(bus.timer_flag), 32'd1);
        base = hs_cnt;
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h85;
        step();
        bus.rsp_valid = 1'b0;
        check("t5_done", 32'(bus.done),      32'd1);
        check("t5_txv",  32'(bus.tx_valid),  32'd0);
        check("t5_rc",   32'(bus.retry_cnt), 32'd0);
        repeat (4) step();
        check("t5_nohs", 32'(hs_cnt - base), 32'd0);

        // 6a: abort in WAIT with a simultaneous matching response
        dbase = done_cnt;
        start_txn(8'h05, 1'b0);
        step();
        check("t6_inwait", 32'(bus.timer_en), 32'd1);
        bus.abort = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h85;
        step();
        bus.abort = 1'b0;
        bus.rsp_valid = 1'b0;
        check_quiet("t6a");
        step();
        check("t6a_dcnt", 32'(done_cnt - dbase), 32'd0);

        // 6b: reset while stalled in SEND
        bus.tx_ready = 1'b0;
        start_txn(8'h3c, 1'b1);
        step();
        check("t6b_txv", 32'(bus.tx_valid), 32'd1);
        check("t6b_msg", 32'(bus.tx_msg),   32'h3c);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("t6b");
        check("t6b_msg0",  32'(bus.tx_msg),     32'h00);
        check("t6b_long0", 32'(bus.timer_long), 32'd0);

        // 6c: normal transaction after reset
        bus.tx_ready = 1'b1;
        start_txn(8'h12, 1'b0);
        check("t6c_txv", 32'(bus.tx_valid), 32'd1);
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_msg = 8'h92;
        step();
        bus.rsp_valid = 1'b0;
        check("t6c_done", 32'(bus.done), 32'd1);
        step();
        check("t6c_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
